wb_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing one pipelined Wishbone slave port among NM masters, e.g. the IPL copy master plus DMA/CPU requesters.
- Grants the bus on cyc, holds it until the owner drops cyc, and stalls losing masters so their strobes are never lost.
- A watchdog terminates a bus owner that gets no ack for TIMEOUT cycles, signalling err to that owner.

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 39 +++
 rtl/wb_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arb_pkg: shared state encodings and default sizing for WB arbiters.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package wb_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_LOCKOUT = 2'd2;

   localparam int DEF_NM      = 4;
   localparam int DEF_TIMEOUT = 255;

   // Watchdog counter width; a disabled watchdog still needs a legal 1-bit vector.
   function automatic int wd_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin selector, scanning from last+1.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NM = DEF_NM
) (
   input  logic [NM-1:0]         i_req,
   input  logic [$clog2(NM)-1:0] i_last,
   output logic                  o_valid,
   output logic [$clog2(NM)-1:0] o_idx
);

   localparam int LW = $clog2(NM);

   int w_k;

   // Scan farthest-first so the nearest requester after i_last overwrites last.
   always_comb begin
      w_k     = 0;
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = NM; i >= 1; i--) begin
         w_k = int'(i_last) + i;
         if (w_k >= NM) begin
            w_k = w_k - NM;
         end
         if (i_req[LW'(w_k)]) begin
            o_valid = 1'b1;
            o_idx   = LW'(w_k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_rr_arbiter: round-robin pipelined-Wishbone arbiter with ack watchdog. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NM         = DEF_NM,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NM-1:0]            m_cyc_i,
   input  logic [NM-1:0]            m_stb_i,
   input  logic [NM-1:0]            m_we_i,
   input  logic [NM*ADDR_WIDTH-1:0] m_adr_i,
   output logic [NM-1:0]            m_ack_o,
   output logic [NM-1:0]            m_stall_o,
   output logic [NM-1:0]            m_err_o,
   output logic                     s_cyc_o,
   output logic                     s_stb_o,
   output logic                     s_we_o,
   output logic [ADDR_WIDTH-1:0]    s_adr_o,
   input  logic                     s_ack_i,
   input  logic                     s_stall_i,
   output logic [NM-1:0]            gnt_o
);

   localparam int LW = $clog2(NM);
   localparam int WW = wd_width(TIMEOUT);

   logic [1:0]    r_state;
   logic [LW-1:0] r_owner;
   logic [LW-1:0] r_last;

   logic          w_owner_cyc;
   logic          w_free;
   logic          w_pick_valid;
   logic [LW-1:0] w_pick_idx;
   logic          w_sel_vld;
   logic [LW-1:0] w_sel;
   logic          w_timeout;

   assign w_owner_cyc = m_cyc_i[r_owner];
   // A GRANT or LOCKOUT owner that has dropped cyc hands the bus back this cycle.
   assign w_free      = (r_state == ST_IDLE) || !w_owner_cyc;

   rr_pick #(
      .NM (NM)
   ) u_pick (
      .i_req   (m_cyc_i),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_sel_vld = w_free ? w_pick_valid : (r_state == ST_GRANT);
   assign w_sel     = w_free ? w_pick_idx   : r_owner;

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam logic [WW-1:0] c_wd_last = WW'(TIMEOUT - 1);
         localparam logic [WW-1:0] c_wd_max  = {WW{1'b1}};

         logic [WW-1:0] r_wd_cnt;

         assign w_timeout = !w_free && (r_state == ST_GRANT) && !s_ack_i
                            && (r_wd_cnt == c_wd_last);

         always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
               r_wd_cnt <= '0;
            end else if (w_free || s_ack_i) begin
               r_wd_cnt <= '0;
            end else if ((r_state == ST_GRANT) && (r_wd_cnt != c_wd_max)) begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
            end
         end
      end else begin : g_no_wd
         assign w_timeout = 1'b0;
      end
   endgenerate

   // Every output is forced low while reset is held, without waiting for a clock.
   always_comb begin
      m_ack_o   = '0;
      m_stall_o = '0;
      m_err_o   = '0;
      gnt_o     = '0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      if (reset_i) begin
         m_stall_o = m_cyc_i;
         if (w_sel_vld) begin
            s_cyc_o          = 1'b1;
            s_stb_o          = m_stb_i[w_sel];
            s_we_o           = m_we_i[w_sel];
            s_adr_o          = m_adr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_o[w_sel]     = 1'b1;
            m_ack_o[w_sel]   = s_ack_i;
            m_stall_o[w_sel] = s_stall_i;
         end
         m_err_o[r_owner] = w_timeout;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= ST_IDLE;
         r_owner <= '0;
         r_last  <= LW'(NM - 1);
      end else if (w_free) begin
         if (w_pick_valid) begin
            r_state <= ST_GRANT;
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
         end else begin
            r_state <= ST_IDLE;
         end
      end else if (w_timeout) begin
         r_state <= ST_LOCKOUT;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_rr_arbiter: directed + randomized checks against a queue-free model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_rr_arbiter;

   localparam int NM = 4;
   localparam int AW = 16;
   localparam int TO = 16;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [NM-1:0] m_cyc_i, m_stb_i, m_we_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM-1:0] m_ack_o, m_stall_o, m_err_o, gnt_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic          s_ack_i, s_stall_i;

   always #5 clk_i = ~clk_i;

   wb_rr_arbiter #(
      .NM         (NM),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_we_i    (m_we_i),
      .m_adr_i   (m_adr_i),
      .m_ack_o   (m_ack_o),
      .m_stall_o (m_stall_o),
      .m_err_o   (m_err_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_adr_o   (s_adr_o),
      .s_ack_i   (s_ack_i),
      .s_stall_i (s_stall_i),
      .gnt_o     (gnt_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, who went last, lockout flag, ack-less run length.
   int  m_has, m_owner, m_last, m_locked, m_run;
   bit  m_free;
   int  m_win;
   logic [NM-1:0] e_gnt, e_ack, e_stall, e_err;
   logic          e_scyc, e_sstb, e_swe;
   logic [AW-1:0] e_sadr;

   task automatic model_reset();
      m_has = 0; m_owner = 0; m_last = NM - 1; m_locked = 0; m_run = 0;
   endtask

   task automatic model_eval();
      int sel;
      m_free = (m_has == 0) || !m_cyc_i[m_owner];
      m_win  = -1;
      if (m_free) begin
         for (int i = 1; i <= NM; i++) begin
            int k;
            k = (m_last + i) % NM;
            if (m_win < 0 && m_cyc_i[k]) m_win = k;
         end
      end
      sel = m_free ? m_win : (m_locked != 0 ? -1 : m_owner);
      e_gnt = '0; e_ack = '0; e_err = '0;
      e_stall = m_cyc_i;
      e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_sadr = '0;
      if (sel >= 0) begin
         e_gnt[sel]   = 1'b1;
         e_ack[sel]   = s_ack_i;
         e_stall[sel] = s_stall_i;
         e_scyc = 1'b1;
         e_sstb = m_stb_i[sel];
         e_swe  = m_we_i[sel];
         e_sadr = m_adr_i[sel*AW +: AW];
      end
      if (!m_free && m_locked == 0 && !s_ack_i && m_run == TO - 1) e_err[m_owner] = 1'b1;
   endtask

   task automatic model_step();
      if (m_free) begin
         m_run = 0;
         if (m_win >= 0) begin
            m_has = 1; m_owner = m_win; m_last = m_win; m_locked = 0;
         end else begin
            m_has = 0;
         end
      end else if (m_locked == 0) begin
         if (s_ack_i) m_run = 0;
         else begin
            if (m_run == TO - 1) m_locked = 1;
            m_run++;
         end
      end
   endtask

   task automatic check_all();
      check_eq("gnt",   gnt_o,     e_gnt);
      check_eq("ack",   m_ack_o,   e_ack);
      check_eq("stall", m_stall_o, e_stall);
      check_eq("err",   m_err_o,   e_err);
      check_eq("s_cyc", s_cyc_o,   e_scyc);
      check_eq("s_stb", s_stb_o,   e_sstb);
      check_eq("s_we",  s_we_o,    e_swe);
      check_eq("s_adr", s_adr_o,   e_sadr);
   endtask

   // Called just after inputs change at a negedge; ends at the next negedge.
   task automatic step_cycle();
      #1;
      model_eval();
      check_all();
      model_step();
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0;
      s_ack_i = 1'b0; s_stall_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b0;
      idle_inputs();
      @(negedge clk_i);
      reset_i = 1'b1;
      model_reset();
   endtask

   int gseq[$];

   initial begin
      logic [NM-1:0] prev_gnt;
      int  beats [NM];
      bit  drop  [NM];
      bit  dead;

      reset_i = 1'b0;
      idle_inputs();
      m_cyc_i = '1; m_stb_i = '1;
      #2;
      check_eq("rst_gnt",   gnt_o,     '0);
      check_eq("rst_stall", m_stall_o, '0);
      check_eq("rst_scyc",  s_cyc_o,   '0);
      @(negedge clk_i);
      reset_i = 1'b1;
      idle_inputs();
      model_reset();

      // Single master, zero-latency forward then ack.
      m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_adr_i[0 +: AW] = 16'h1234;
      #1;
      check_eq("single_scyc", s_cyc_o, 1'b1);
      check_eq("single_adr",  s_adr_o, 16'h1234);
      check_eq("single_gnt",  gnt_o,   4'b0001);
      step_cycle();
      m_stb_i = '0; s_ack_i = 1'b1;
      #1;
      check_eq("single_ack", m_ack_o, 4'b0001);
      step_cycle();
      idle_inputs();
      step_cycle();

      // Contention from reset: 0 and 2 together.
      do_reset();
      m_cyc_i = 4'b0101; m_stb_i = 4'b0101;
      m_adr_i[0 +: AW] = 16'hAAAA; m_adr_i[2*AW +: AW] = 16'h2222;
      s_ack_i = 1'b1;
      #1;
      check_eq("cont_gnt0",   gnt_o,     4'b0001);
      check_eq("cont_stall2", m_stall_o, 4'b0100);
      step_cycle();
      step_cycle();
      m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
      #1;
      check_eq("cont_gnt2", gnt_o,   4'b0100);
      check_eq("cont_adr2", s_adr_o, 16'h2222);
      step_cycle();
      idle_inputs();
      step_cycle();

      // Fairness: 2-beat back-to-back cycles from all masters.
      do_reset();
      s_ack_i = 1'b1;
      prev_gnt = '0;
      for (int k = 0; k < NM; k++) begin beats[k] = 0; drop[k] = 1'b0; end
      for (int c = 0; c < 20; c++) begin
         for (int k = 0; k < NM; k++) begin
            m_cyc_i[k] = !drop[k];
            m_stb_i[k] = !drop[k];
            m_adr_i[k*AW +: AW] = 16'($urandom);
         end
         #1;
         if (gnt_o != prev_gnt && gnt_o != '0)
            for (int k = 0; k < NM; k++) if (gnt_o[k]) gseq.push_back(k);
         prev_gnt = gnt_o;
         for (int k = 0; k < NM; k++) begin
            drop[k] = 1'b0;
            if (gnt_o[k]) begin
               beats[k]++;
               if (beats[k] == 2) begin beats[k] = 0; drop[k] = 1'b1; end
            end
         end
         step_cycle();
      end
      check_eq("fair_len", (gseq.size() >= 6), 1'b1);
      for (int i = 0; i < 6 && i < gseq.size(); i++) check_eq("fair_seq", gseq[i], i % NM);
      idle_inputs();
      step_cycle();

      // Watchdog: owner 1 never acked, master 3 waiting.
      do_reset();
      m_cyc_i = 4'b1010; m_stb_i = 4'b1010;
      step_cycle();
      for (int c = 1; c <= TO; c++) begin
         #1;
         check_eq("wd_err", m_err_o, (c == TO) ? 4'b0010 : 4'b0000);
         step_cycle();
      end
      #1;
      check_eq("wd_lock_scyc",  s_cyc_o,   1'b0);
      check_eq("wd_lock_stall", m_stall_o, 4'b1010);
      step_cycle();
      m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
      #1;
      check_eq("wd_next_gnt", gnt_o, 4'b1000);
      step_cycle();
      idle_inputs();
      step_cycle();

      // Ack collides with the final watchdog cycle: ack wins and the count restarts.
      do_reset();
      m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
      step_cycle();
      for (int c = 1; c < TO; c++) step_cycle();
      s_ack_i = 1'b1;
      #1;
      check_eq("coll_err", m_err_o, 4'b0000);
      step_cycle();
      s_ack_i = 1'b0;
      for (int c = 1; c <= TO; c++) begin
         #1;
         check_eq("coll_restart", m_err_o, (c == TO) ? 4'b0100 : 4'b0000);
         step_cycle();
      end
      idle_inputs();
      step_cycle();

      // Randomized traffic.
      dead = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) dead = ($urandom_range(2) == 0);
         for (int k = 0; k < NM; k++) begin
            if (m_cyc_i[k]) begin
               if ($urandom_range(15) == 0) m_cyc_i[k] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               m_cyc_i[k] = 1'b1;
            end
            m_stb_i[k] = m_cyc_i[k] & 1'($urandom_range(1));
            m_we_i[k]  = 1'($urandom_range(1));
            m_adr_i[k*AW +: AW] = 16'($urandom);
         end
         s_ack_i   = dead ? 1'b0 : 1'($urandom_range(1));
         s_stall_i = ($urandom_range(3) == 0);
         step_cycle();
      end

      // Reset mid-transfer with the slave stalling.
      m_cyc_i = '1; m_stb_i = '1; s_stall_i = 1'b1; s_ack_i = 1'b0;
      step_cycle();
      #2;
      reset_i = 1'b0;
      #1;
      check_eq("mid_rst_scyc",  s_cyc_o,   1'b0);
      check_eq("mid_rst_gnt",   gnt_o,     '0);
      check_eq("mid_rst_stall", m_stall_o, '0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b1;
      model_reset();
      #1;
      check_eq("post_rst_gnt", gnt_o, 4'b0001);
      step_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
